// File: rtl/conv_enc_pkg.sv
// rtl/conv_enc_pkg.sv - shared state type, generator constants and parity helper for the convolutional encoder
package conv_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL
    } enc_state_t;

    localparam int MAX_K = 9;

    // Generator j=0 occupies the LSBs of the packed vector
    localparam logic [5:0]  G_K3_R12 = {3'o5, 3'o7};
    localparam logic [11:0] G_K4_R13 = {4'o17, 4'o15, 4'o13};

    function automatic logic conv_parity(input logic [MAX_K-1:0] g, input logic [MAX_K-1:0] v);
        return ^(g & v);
    endfunction

endpackage

// File: rtl/conv_enc_serializer.sv
// rtl/conv_enc_serializer.sv - N-bit load/shift output buffer with valid/ready and end-of-frame flag
module conv_enc_serializer #(
    parameter int N = 2
) (
    input  logic         clk_2,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         load_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_last,
    output logic         word_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  sr;
    logic [IW-1:0] idx;
    logic          frame_last;

    assign word_done = out_valid && out_ready && (idx == IW'(N-1));

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            sr         <= '0;
            idx        <= '0;
            frame_last <= 1'b0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            out_last   <= 1'b0;
        end else if (load) begin
            // A load may coincide with the final-bit handshake; it wins so codewords run gap-free
            sr         <= load_data >> 1;
            out_bit    <= load_data[0];
            idx        <= '0;
            frame_last <= load_last;
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (idx == IW'(N-1)) begin
                idx        <= '0;
                frame_last <= 1'b0;
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
            end else begin
                sr       <= sr >> 1;
                out_bit  <= sr[0];
                idx      <= idx + IW'(1);
                out_last <= frame_last && (idx == IW'(N-2));
            end
        end
    end

endmodule

// File: rtl/conv_encoder_serial.sv
// rtl/conv_encoder_serial.sv - rate-1/N constraint-length-K convolutional encoder with serial code-bit output
module conv_encoder_serial
    import conv_enc_pkg::*;
#(
    parameter int             K    = 3,
    parameter int             N    = 2,
    parameter logic [N*K-1:0] G    = G_K3_R12,
    parameter bit             TAIL = 1'b1
) (
    input  logic clk_2,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_data,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last,
    output logic busy
);

    localparam int SW = K - 1;

    enc_state_t    state;
    logic [SW-1:0] sreg;
    logic [3:0]    tail_cnt;
    logic          cur_last;
    logic          word_done;
    logic          accept;
    logic          d_eff;
    logic          load;
    logic          load_last;
    logic [K-1:0]  v;
    logic [N-1:0]  cw;

    assign in_ready = (state == ST_IDLE) || (state == ST_DATA && word_done && !cur_last);
    assign accept   = in_valid && in_ready;
    assign d_eff    = accept ? in_data : 1'b0;

    // v[K-1] is the incoming bit, v[0] the oldest register bit
    always_comb begin
        v      = '0;
        v[K-1] = d_eff;
        for (int i = 0; i < SW; i++) begin
            v[SW-1-i] = sreg[i];
        end
        cw = '0;
        for (int j = 0; j < N; j++) begin
            cw[j] = conv_parity(MAX_K'(G[j*K +: K]), MAX_K'(v));
        end
    end

    always_comb begin
        load      = 1'b0;
        load_last = 1'b0;
        case (state)
            ST_IDLE: begin
                load      = accept;
                load_last = in_last && !TAIL;
            end
            ST_DATA: begin
                if (word_done) begin
                    if (accept) begin
                        load      = 1'b1;
                        load_last = in_last && !TAIL;
                    end else if (cur_last && TAIL) begin
                        load      = 1'b1;
                        load_last = (K == 2);
                    end
                end
            end
            ST_TAIL: begin
                if (word_done && tail_cnt != 4'(K-2)) begin
                    load      = 1'b1;
                    load_last = (tail_cnt == 4'(K-3));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            tail_cnt <= '0;
            cur_last <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (accept) begin
                sreg     <= SW'({sreg, in_data});
                cur_last <= in_last;
            end else if (load) begin
                sreg <= SW'({sreg, 1'b0});
            end
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (word_done && !accept) begin
                        if (cur_last && TAIL) begin
                            state    <= ST_TAIL;
                            tail_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                            // Unterminated frames still restart from the all-zero state
                            if (cur_last) sreg <= '0;
                        end
                    end
                end
                ST_TAIL: begin
                    if (word_done) begin
                        if (tail_cnt == 4'(K-2)) begin
                            state    <= ST_IDLE;
                            tail_cnt <= '0;
                        end else begin
                            tail_cnt <= tail_cnt + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (accept) busy <= 1'b1;
            else if (out_valid && out_ready && out_last) busy <= 1'b0;
        end
    end

    conv_enc_serializer #(.N(N)) u_ser (
        .clk_2     (clk_2),
        .reset     (reset),
        .load      (load),
        .load_data (cw),
        .load_last (load_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_conv_encoder_serial.sv
// tb/tb_conv_encoder_serial.sv - bench for conv_encoder_serial in three parameterisations
module tb_conv_encoder_serial;

    logic clk_2 = 1'b0;
    logic reset;
    logic in_valid [3];
    logic in_ready [3];
    logic in_data  [3];
    logic in_last  [3];
    logic out_valid[3];
    logic out_ready[3];
    logic out_bit  [3];
    logic out_last [3];
    logic busy     [3];

    int          mk[3] = '{3, 3, 4};
    int          mn[3] = '{2, 2, 3};
    bit          mt[3] = '{1'b1, 1'b0, 1'b1};
    logic [11:0] mg[3] = '{12'b000000_101111, 12'b000000_101111, 12'b1111_1101_1011};

    int duty[3] = '{100, 100, 100};
    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int cyc = 0;
    bit got_b[3][$];
    bit got_l[3][$];
    int got_c[3][$];
    bit rdy_after_last[$];
    int stall_err = 0, tail_err = 0;
    int flen0 = 99, fcnt0 = 0;
    bit prev_stall[3], prev_sb[3], prev_sl[3];
    bit prev_lhs = 1'b0;

    conv_encoder_serial #(.K(3), .N(2), .G(6'b101111), .TAIL(1'b1)) u_a (
        .clk_2(clk_2), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_bit(out_bit[0]), .out_last(out_last[0]), .busy(busy[0]));

    conv_encoder_serial #(.K(3), .N(2), .G(6'b101111), .TAIL(1'b0)) u_b (
        .clk_2(clk_2), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_bit(out_bit[1]), .out_last(out_last[1]), .busy(busy[1]));

    conv_encoder_serial #(.K(4), .N(3), .G(12'b1111_1101_1011), .TAIL(1'b1)) u_c (
        .clk_2(clk_2), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_bit(out_bit[2]), .out_last(out_last[2]), .busy(busy[2]));

    always #5 clk_2 = ~clk_2;
    always @(posedge clk_2) cyc <= cyc + 1;

    initial begin
        for (int u = 0; u < 3; u++) out_ready[u] = 1'b1;
        forever begin
            @(posedge clk_2); #1;
            for (int u = 0; u < 3; u++) out_ready[u] = ($urandom_range(0, 99) < duty[u]);
        end
    end

    always @(negedge clk_2) begin
        if (!reset) begin
            for (int u = 0; u < 3; u++) begin
                got_b[u].delete(); got_l[u].delete(); got_c[u].delete();
                prev_stall[u] = 1'b0;
            end
            fcnt0    = 0;
            prev_lhs = 1'b0;
        end else begin
            for (int u = 0; u < 3; u++) begin
                if (prev_stall[u] && !(out_valid[u] === 1'b1 && out_bit[u] === prev_sb[u] && out_last[u] === prev_sl[u]))
                    stall_err++;
                prev_stall[u] = out_valid[u] && !out_ready[u];
                prev_sb[u]    = out_bit[u];
                prev_sl[u]    = out_last[u];
                if (out_valid[u] && out_ready[u]) begin
                    got_b[u].push_back(out_bit[u]);
                    got_l[u].push_back(out_last[u]);
                    got_c[u].push_back(cyc);
                end
            end
            if (prev_lhs) rdy_after_last.push_back(in_ready[0]);
            if (fcnt0 >= flen0 * 2 && fcnt0 < (flen0 + 2) * 2 && in_ready[0]) tail_err++;
            prev_lhs = out_valid[0] && out_ready[0] && out_last[0];
            if (out_valid[0] && out_ready[0]) fcnt0 = out_last[0] ? 0 : fcnt0 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sentinel 1 in front keeps stream length visible in the packed value
    function automatic logic [63:0] pack(input bit q[$]);
        logic [63:0] r;
        r = 64'd1;
        foreach (q[i]) r = {r[62:0], q[i]};
        return r;
    endfunction

    // Reference: code bit j at step t is the parity of generator j against the last K inputs of the frame
    function automatic void model(input int u, input bit d[$], output bit ob[$], output bit ol[$]);
        bit seq[$];
        bit acc;
        seq = d;
        if (mt[u]) repeat (mk[u] - 1) seq.push_back(1'b0);
        ob = {};
        ol = {};
        foreach (seq[t]) begin
            for (int j = 0; j < mn[u]; j++) begin
                acc = 1'b0;
                for (int m = 0; m < mk[u]; m++)
                    if (t - m >= 0) acc ^= mg[u][j*mk[u] + mk[u] - 1 - m] & seq[t-m];
                ob.push_back(acc);
                ol.push_back(t == seq.size() - 1 && j == mn[u] - 1);
            end
        end
    endfunction

    task automatic drive_bit(input int u, input bit d, input bit l);
        int n;
        n = 0;
        in_valid[u] = 1'b1; in_data[u] = d; in_last[u] = l;
        @(negedge clk_2);
        while (!in_ready[u] && n < 1000) begin
            n++;
            @(negedge clk_2);
        end
        if (n >= 1000) check("in_ready_timeout", 64'(n), 64'd0);
        @(posedge clk_2); #1;
    endtask

    task automatic send_frame(input int u, input bit d[$], input bit l[$]);
        @(posedge clk_2); #1;
        foreach (d[i]) drive_bit(u, d[i], l[i]);
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic wait_bits(input int u, input int cnt);
        int n;
        n = 0;
        while (got_b[u].size() < cnt && n < 5000) begin
            @(negedge clk_2); #1;
            n++;
        end
        check("wait_bits", 64'(got_b[u].size()), 64'(cnt));
    endtask

    task automatic run(input int u, input bit d[$], input bit l[$], input string tag);
        bit eb[$], el[$];
        got_b[u].delete(); got_l[u].delete(); got_c[u].delete();
        model(u, d, eb, el);
        send_frame(u, d, l);
        wait_bits(u, eb.size());
        check({tag, "_bits"}, pack(got_b[u]), pack(eb));
        check({tag, "_last"}, pack(got_l[u]), pack(el));
        @(posedge clk_2); #1;
        check({tag, "_busy_end"}, 64'({busy[u], out_valid[u]}), 64'd0);
    endtask

    initial begin
        bit d[$], l[$], e1[$], f1[$], e2[$], f2[$];
        int len;
        reset = 1'b0;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; in_data[u] = 1'b0; in_last[u] = 1'b0;
        end
        repeat (2) @(negedge clk_2);
        #1;
        for (int u = 0; u < 3; u++)
            check("reset_state", 64'({out_valid[u], out_bit[u], out_last[u], busy[u], in_ready[u]}), 64'b00001);
        @(negedge clk_2);
        reset = 1'b1;

        d = '{1, 0, 1, 1}; l = '{0, 0, 0, 1};
        flen0 = 4;
        run(0, d, l, "k3_tail");
        check("k3_tail_const", pack(got_b[0]), 64'({1'b1, 12'b11_10_00_01_01_11}));
        check("k3_tail_last_const", pack(got_l[0]), 64'({1'b1, 12'b00_00_00_00_00_01}));

        run(1, d, l, "k3_notail");
        check("k3_notail_const", pack(got_b[1]), 64'({1'b1, 8'b11_10_00_01}));
        check("k3_notail_last_const", pack(got_l[1]), 64'({1'b1, 8'b00_00_00_01}));
        d = '{1}; l = '{1};
        run(1, d, l, "k3_notail_next");
        check("k3_notail_next_const", pack(got_b[1]), 64'({1'b1, 2'b11}));
        check("k3_notail_next_last", pack(got_l[1]), 64'({1'b1, 2'b01}));

        run(2, d, l, "k4_r13");
        check("k4_r13_const", pack(got_b[2]), 64'({1'b1, 12'b111_011_101_111}));
        check("k4_r13_last_const", pack(got_l[2]), 64'({1'b1, 12'b000_000_000_001}));

        d = '{1, 0, 1, 1}; l = '{0, 0, 0, 1};
        duty[0] = 30;
        run(0, d, l, "backpressure");
        check("backpressure_const", pack(got_b[0]), 64'({1'b1, 12'b11_10_00_01_01_11}));
        duty[0] = 100;
        check("stall_stable", 64'(stall_err), 64'd0);
        check("tail_in_ready_low", 64'(tail_err), 64'd0);

        flen0 = 99;
        got_b[0].delete(); got_l[0].delete();
        d = '{1, 0, 1}; l = '{0, 0, 0};
        send_frame(0, d, l);
        wait_bits(0, 5);
        reset = 1'b0;
        #1;
        check("midreset_immediate", 64'({out_valid[0], out_bit[0], out_last[0], busy[0]}), 64'd0);
        repeat (2) @(negedge clk_2);
        #1;
        for (int u = 0; u < 3; u++)
            check("midreset_hold", 64'({out_valid[u], out_bit[u], out_last[u], busy[u], in_ready[u]}), 64'b00001);
        @(negedge clk_2);
        reset = 1'b1;
        flen0 = 4;
        d = '{1, 0, 1, 1}; l = '{0, 0, 0, 1};
        run(0, d, l, "after_reset");
        check("after_reset_const", pack(got_b[0]), 64'({1'b1, 12'b11_10_00_01_01_11}));

        got_b[0].delete(); got_l[0].delete(); got_c[0].delete();
        rdy_after_last.delete();
        model(0, '{1, 0, 1, 1}, e1, f1);
        model(0, '{0, 1, 1, 0}, e2, f2);
        d = '{1, 0, 1, 1, 0, 1, 1, 0}; l = '{0, 0, 0, 1, 0, 0, 0, 1};
        send_frame(0, d, l);
        wait_bits(0, 24);
        check("b2b_bits", pack(got_b[0]), pack({e1, e2}));
        check("b2b_last", pack(got_l[0]), pack({f1, f2}));
        check("b2b_frame1_contig", 64'(got_c[0][11] - got_c[0][0]), 64'd11);
        check("b2b_frame2_contig", 64'(got_c[0][23] - got_c[0][12]), 64'd11);
        check("b2b_frame_gap", 64'(got_c[0][12] - got_c[0][11]), 64'd2);
        check("b2b_in_ready_after_last", 64'(rdy_after_last.size() > 0 && rdy_after_last[0]), 64'd1);
        @(posedge clk_2); #1;

        for (int it = 0; it < 9; it++) begin
            int u;
            u = it % 3;
            len = $urandom_range(1, 6);
            d.delete(); l.delete();
            for (int i = 0; i < len; i++) begin
                d.push_back(1'($urandom_range(0, 1)));
                l.push_back(i == len - 1);
            end
            duty[u] = $urandom_range(30, 100);
            if (u == 0) flen0 = len;
            run(u, d, l, $sformatf("rand%0d_u%0d", it, u));
            duty[u] = 100;
        end
        check("final_stall_stable", 64'(stall_err), 64'd0);
        check("final_tail_in_ready_low", 64'(tail_err), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
